// File: rtl/llf_drain_scheduler_pkg.sv
// Shared types and helpers for the linked-list FIFO drain scheduler.
// Holds the index-width helper and the output buffer credit limit.
package llf_drain_scheduler_pkg;

    // Entries in the output buffer; pops are throttled against this.
    localparam int OUT_BUF_DEPTH = 2;

    // Bits needed to represent x (minimum 1), matching the FIFO's helper.
    function automatic int log2(input int x);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((x >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/llf_out_buf.sv
// Two-entry {data, id} register FIFO with occupancy output.
// Head lives in slot 0; a dequeue shifts slot 1 down.
module llf_out_buf
    import llf_drain_scheduler_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_i,
    input  logic [WIDTH-1:0] enq_data_i,
    input  logic [IDW-1:0]   enq_id_i,
    input  logic             deq_i,
    output logic [1:0]       occ_o,
    output logic [WIDTH-1:0] head_data_o,
    output logic [IDW-1:0]   head_id_o
);

    logic [WIDTH-1:0] data_q [2];
    logic [WIDTH-1:0] data_d [2];
    logic [IDW-1:0]   id_q   [2];
    logic [IDW-1:0]   id_d   [2];
    logic [1:0]       occ_q, occ_d;
    logic [1:0]       wpos;
    logic             full;
    logic             accept;

    assign full   = (occ_q == 2'(OUT_BUF_DEPTH));
    assign wpos   = occ_q - {1'b0, deq_i};
    assign accept = enq_i & ~wpos[1];

    assign occ_o       = occ_q;
    assign head_data_o = data_q[0];
    assign head_id_o   = id_q[0];

    // Shift on dequeue, then write the new word behind the survivors.
    always_comb begin
        data_d = data_q;
        id_d   = id_q;
        if (deq_i) begin
            data_d[0] = data_q[1];
            id_d[0]   = id_q[1];
        end
        if (accept) begin
            data_d[wpos[0]] = enq_data_i;
            id_d[wpos[0]]   = enq_id_i;
        end
        occ_d = occ_q + {1'b0, accept} - {1'b0, deq_i};
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                id_q[i]   <= '0;
            end
            occ_q <= '0;
        end else begin
            data_q <= data_d;
            id_q   <= id_d;
            occ_q  <= occ_d;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(enq_i && full && !deq_i)
    );

endmodule

// File: rtl/llf_drain_scheduler.sv
// Round-robin pop-side reader for the shared-RAM multi-queue FIFO.
// Waits out link init, then pops under a 2-word credit limit.
module llf_drain_scheduler
    import llf_drain_scheduler_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 32,
    parameter int FIFOS       = 8,
    parameter int LOG2_FIFOS  = log2(FIFOS - 1),
    parameter int INIT_CYCLES = DEPTH + 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFOS-1:0]      enable_mask,
    output logic                  fifo_pop,
    output logic [LOG2_FIFOS-1:0] fifo_pop_fifo,
    input  logic                  fifo_empty,
    input  logic [WIDTH-1:0]      fifo_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [LOG2_FIFOS-1:0] out_fifo,
    output logic                  idle
);

    localparam int CNT_W = log2(INIT_CYCLES);
    localparam logic [LOG2_FIFOS-1:0] LAST_Q = LOG2_FIFOS'(FIFOS - 1);

    logic [CNT_W-1:0]      init_cnt_q, init_cnt_d;
    logic [LOG2_FIFOS-1:0] rr_q, rr_d;
    logic [LOG2_FIFOS-1:0] inflight_id_q, inflight_id_d;
    logic                  inflight_q, inflight_d;
    logic                  init_done;
    logic                  deq;
    logic                  credit_ok;
    logic [1:0]            occ;
    logic [2:0]            pending;

    assign init_done = (init_cnt_q == CNT_W'(INIT_CYCLES));
    assign deq       = out_valid & out_ready;
    // Words buffered or on their way, minus the one leaving now.
    assign pending   = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, deq};
    assign credit_ok = (pending < 3'(OUT_BUF_DEPTH));

    assign fifo_pop_fifo = rr_q;
    assign fifo_pop = init_done & enable_mask[rr_q] & ~fifo_empty
                    & credit_ok;
    assign out_valid = (occ != 2'd0);
    assign idle = init_done & (occ == 2'd0) & ~inflight_q & ~fifo_pop;

    // Next state: saturating init count, free-running rotation, read tag.
    always_comb begin
        init_cnt_d    = init_cnt_q;
        rr_d          = rr_q;
        inflight_d    = fifo_pop;
        inflight_id_d = inflight_id_q;
        if (!init_done) begin
            init_cnt_d = init_cnt_q + CNT_W'(1);
        end else begin
            rr_d = (rr_q == LAST_Q) ? '0 : rr_q + LOG2_FIFOS'(1);
        end
        if (fifo_pop) inflight_id_d = rr_q;
    end

    // State registers; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_q    <= '0;
            rr_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_id_q <= '0;
        end else begin
            init_cnt_q    <= init_cnt_d;
            rr_q          <= rr_d;
            inflight_q    <= inflight_d;
            inflight_id_q <= inflight_id_d;
        end
    end

    llf_out_buf #(
        .WIDTH (WIDTH),
        .IDW   (LOG2_FIFOS)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .enq_i       (inflight_q),
        .enq_data_i  (fifo_q),
        .enq_id_i    (inflight_id_q),
        .deq_i       (deq),
        .occ_o       (occ),
        .head_data_o (out_data),
        .head_id_o   (out_fifo)
    );

endmodule

// File: tb/tb_llf_drain_scheduler.sv
// Scoreboard bench for llf_drain_scheduler with a behavioural FIFO model.
// A second instance with FIFOS=1 covers back-to-back throughput.
module tb_llf_drain_scheduler;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] enable_mask = 8'hFF;
    logic       fifo_pop;
    logic [2:0] fifo_pop_fifo;
    logic       fifo_empty;
    logic [7:0] fifo_q = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic [2:0] out_fifo;
    logic       idle;

    logic       mask1 = 1'b1;
    logic       pop1;
    logic [0:0] ptr1;
    logic       empty1;
    logic [7:0] q1 = 8'h00;
    logic       valid1;
    logic       ready1 = 1'b1;
    logic [7:0] data1;
    logic [0:0] fifo1;
    logic       idle1;

    llf_drain_scheduler dut (
        .clk(clk), .rst(rst), .enable_mask(enable_mask),
        .fifo_pop(fifo_pop), .fifo_pop_fifo(fifo_pop_fifo),
        .fifo_empty(fifo_empty), .fifo_q(fifo_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_fifo(out_fifo), .idle(idle)
    );

    llf_drain_scheduler #(.FIFOS(1)) dut1 (
        .clk(clk), .rst(rst), .enable_mask(mask1),
        .fifo_pop(pop1), .fifo_pop_fifo(ptr1),
        .fifo_empty(empty1), .fifo_q(q1),
        .out_valid(valid1), .out_ready(ready1),
        .out_data(data1), .out_fifo(fifo1), .idle(idle1)
    );

    // Behavioural multi-queue FIFO: registered read data, flags after edge.
    logic [7:0] mem [8][$];
    logic [7:0] mem1 [$];
    logic [7:0] empty_vec = 8'hFF;
    logic       empty1_q = 1'b1;
    logic       push_v = 1'b0;
    logic [2:0] push_id = 3'd0;
    logic [7:0] push_d = 8'h00;
    logic       load1 = 1'b0;

    assign fifo_empty = empty_vec[fifo_pop_fifo];
    assign empty1     = empty1_q;

    always @(posedge clk) begin
        if (fifo_pop === 1'b1) fifo_q <= mem[fifo_pop_fifo].pop_front();
        if (push_v) mem[push_id].push_back(push_d);
        for (int i = 0; i < 8; i++) empty_vec[i] <= (mem[i].size() == 0);
        if (pop1 === 1'b1) q1 <= mem1.pop_front();
        if (load1) for (int k = 0; k < 10; k++) mem1.push_back(8'h40 + 8'(k));
        empty1_q <= (mem1.size() == 0);
    end

    logic [10:0] exp_q [$];
    logic [10:0] mon_e;
    int total = 0;
    int bad = 0;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] id, input logic [7:0] d,
                        input bit e);
        push_v = 1'b1;
        push_id = id;
        push_d = d;
        if (e) exp_q.push_back({id, d});
        tick();
        push_v = 1'b0;
    endtask

    task automatic observe(input int cycles, input logic [2:0] pq,
                           input logic [7:0] pbase, input int pn,
                           input bit pexp, output int np, output int nq);
        np = 0;
        nq = 0;
        for (int c = 0; c < cycles; c++) begin
            push_v = (c < pn);
            push_id = pq;
            push_d = pbase + 8'(c);
            if (c < pn && pexp) exp_q.push_back({pq, 8'(pbase + 8'(c))});
            @(negedge clk);
            if (fifo_pop) begin
                np++;
                if (fifo_pop_fifo == pq) nq++;
            end
            tick();
        end
        push_v = 1'b0;
    endtask

    task automatic wait_idle(input string n, input int budget);
        int k;
        k = 0;
        while (!(idle === 1'b1 && exp_q.size() == 0) && k < budget) begin
            tick();
            k++;
        end
        chk(n, {31'd0, idle}, 32'd1);
    endtask

    int np, nq, npop, nv, nchg, n;
    logic [13:0] pbits, vbits;
    logic [10:0] held;

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (out_valid === 1'b1 && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_extra", {21'd0, out_fifo, out_data}, 32'd0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("sb_word", {21'd0, out_fifo, out_data},
                            {21'd0, mon_e});
                    end
                end
            end
        join_none

        // Test 1: init wait with every queue loaded, FIFOS=1 preloaded.
        tick();
        tick();
        rst = 1'b0;
        npop = 0;
        for (int c = 0; c < 36; c++) begin
            push_v = (c < 8);
            push_id = 3'(c);
            push_d = 8'hA0 + 8'(c);
            if (c < 8) exp_q.push_back({3'(c), 8'(8'hA0 + 8'(c))});
            load1 = (c == 8);
            @(negedge clk);
            if (c == 0) begin
                chk("rst_pop", {31'd0, fifo_pop}, 32'd0);
                chk("rst_valid", {31'd0, out_valid}, 32'd0);
                chk("rst_data", {24'd0, out_data}, 32'd0);
                chk("rst_fifo", {29'd0, out_fifo}, 32'd0);
                chk("rst_idle", {31'd0, idle}, 32'd0);
                chk("rst_ptr", {29'd0, fifo_pop_fifo}, 32'd0);
            end
            npop += int'(fifo_pop) + int'(pop1);
            tick();
        end
        push_v = 1'b0;
        load1 = 1'b0;
        chk("init_pops", npop, 0);

        // Test 3 window on the single-queue instance; test 1 first pop.
        nv = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("first_pop", {31'd0, fifo_pop}, 32'd1);
                chk("first_ptr", {29'd0, fifo_pop_fifo}, 32'd0);
            end
            pbits[c] = pop1;
            vbits[c] = valid1;
            if (valid1 === 1'b1) begin
                chk("u1_data", {23'd0, fifo1, data1},
                    {24'd0, 8'(8'h40 + 8'(nv))});
                nv++;
            end
            tick();
        end
        chk("u1_pops", {18'd0, pbits}, 32'h03FF);
        chk("u1_valid", {18'd0, vbits}, 32'h0FFC);
        wait_idle("t1_idle", 100);
        chk("u1_idle", {31'd0, idle1}, 32'd1);

        // Test 2: only queue 3 holds words.
        observe(40, 3'd3, 8'hC0, 3, 1'b1, np, nq);
        chk("t2_pops", np, 3);
        chk("t2_q3_pops", nq, 3);
        wait_idle("t2_idle", 100);

        // Test 4: consumer stalls while queue 0 keeps data.
        out_ready = 1'b0;
        observe(40, 3'd0, 8'h50, 6, 1'b1, np, nq);
        chk("t4_stall_pops", np, 2);
        @(negedge clk);
        chk("t4_valid", {31'd0, out_valid}, 32'd1);
        held = {out_fifo, out_data};
        nchg = 0;
        npop = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if ({out_fifo, out_data} !== held) nchg++;
            npop += int'(fifo_pop);
            tick();
        end
        chk("t4_hold", nchg, 0);
        chk("t4_no_pop", npop, 0);
        out_ready = 1'b1;
        wait_idle("t4_idle", 200);

        // Test 5: mask restricts service to queue 1 until bit 5 is set.
        enable_mask = 8'h02;
        push(3'd5, 8'h55, 1'b0);
        push(3'd5, 8'h56, 1'b0);
        observe(40, 3'd1, 8'h10, 2, 1'b1, np, nq);
        chk("t5_pops", np, 2);
        chk("t5_q1_pops", nq, 2);
        wait_idle("t5_idle", 100);
        enable_mask = 8'h22;
        exp_q.push_back({3'd5, 8'h55});
        exp_q.push_back({3'd5, 8'h56});
        observe(40, 3'd5, 8'h00, 0, 1'b0, np, nq);
        chk("t5_q5_pops", nq, 2);
        wait_idle("t5_idle2", 100);

        // Test 6: reset right after a pop drops the returning word.
        enable_mask = 8'h00;
        push(3'd0, 8'h61, 1'b0);
        push(3'd0, 8'h62, 1'b1);
        enable_mask = 8'h01;
        n = 0;
        @(negedge clk);
        while (fifo_pop !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_pop_seen", {31'd0, fifo_pop}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        npop = 0;
        nv = 0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            npop += int'(fifo_pop);
            nv += int'(out_valid);
            tick();
        end
        chk("t6_init_pops", npop, 0);
        chk("t6_no_out", nv, 0);
        @(negedge clk);
        chk("t6_repop", {31'd0, fifo_pop}, 32'd1);
        tick();
        wait_idle("t6_idle", 100);

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
